// File: rtl/lzw_dict_pkg.sv
// Shared LZW dictionary definitions.
// Field layout of the sync word, code range and the forward FSM states.
package lzw_dict_pkg;

  localparam int CODE_W = 14;
  localparam int CHAR_W = 8;
  localparam int SYNC_W = 1 + CODE_W + CHAR_W;
  localparam int SYNC_VALID_BIT = SYNC_W - 1;

  localparam logic [CODE_W-1:0] FIRST_CODE = 14'h100;
  localparam logic [CODE_W-1:0] LAST_CODE  = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_ADD   = 2'd0,
    ST_FULL  = 2'd1,
    ST_CLEAR = 2'd2
  } dict_state_e;

endpackage

// File: rtl/lzw_stat_cnt.sv
// Saturating statistic counter.
// Synchronous clear has priority over increment.
module lzw_stat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count events, stick at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lzw_forward_dictionary_sync.sv
// Forward-side dictionary sync generator.
// Allocates codes, mirrors entries to the backward dictionary, clears on restart.
module lzw_forward_dictionary_sync #(
  parameter int CODE_W = lzw_dict_pkg::CODE_W,
  parameter int CHAR_W = lzw_dict_pkg::CHAR_W,
  parameter logic [CODE_W-1:0] FIRST_CODE = lzw_dict_pkg::FIRST_CODE,
  parameter logic [CODE_W-1:0] LAST_CODE  = lzw_dict_pkg::LAST_CODE
) (
  input  logic                     I_sys_clk,
  input  logic                     I_sys_rst,
  input  logic                     I_state_clr,
  input  logic                     I_entry_valid,
  input  logic [CODE_W-1:0]        I_entry_prefix,
  input  logic [CHAR_W-1:0]        I_entry_char,
  output logic                     O_entry_ready,
  input  logic                     I_dict_reset,
  output logic [CODE_W+CHAR_W:0]   O_dictionary_sync_data,
  output logic [CODE_W-1:0]        O_dictionary_sync_addr,
  output logic                     O_dictionary_sync_wren,
  output logic [CODE_W-1:0]        O_next_code,
  output logic                     O_dict_full,
  output logic [31:0]              O_entry_cnt,
  output logic [15:0]              O_clear_cnt,
  output logic [15:0]              O_err_cnt
);

  import lzw_dict_pkg::*;

  localparam int SW = CODE_W + CHAR_W + 1;

  dict_state_e       r_state;
  logic [CODE_W-1:0] r_next_code;
  logic [CODE_W-1:0] r_clr_addr;
  logic [CODE_W-1:0] r_sync_addr;
  logic [SW-1:0]     r_sync_data;
  logic              r_sync_wren;
  logic              r_full;

  logic w_accept;
  logic w_legal;
  logic w_illegal;
  logic w_at_last;
  logic w_clr_done;

  assign w_accept   = I_entry_valid & (r_state == ST_ADD);
  assign w_legal    = w_accept & (I_entry_prefix < r_next_code);
  assign w_illegal  = w_accept & ~(I_entry_prefix < r_next_code);
  assign w_at_last  = (r_next_code == LAST_CODE);
  assign w_clr_done = (r_state == ST_CLEAR) & (r_clr_addr == LAST_CODE);

  // allocation, full detection and clear sweep
  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      r_state     <= ST_ADD;
      r_next_code <= FIRST_CODE;
      r_clr_addr  <= FIRST_CODE;
      r_sync_addr <= '0;
      r_sync_data <= '0;
      r_sync_wren <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_sync_wren <= 1'b0;
      unique case (r_state)
        ST_ADD: begin
          if (w_legal) begin
            r_sync_wren <= 1'b1;
            r_sync_addr <= r_next_code;
            r_sync_data <= {1'b1, I_entry_prefix, I_entry_char};
            if (w_at_last) begin
              r_full  <= 1'b1;
              r_state <= ST_FULL;
            end else begin
              r_next_code <= r_next_code + 1'b1;
            end
          end
          // restart wins over the full transition; sweep follows the write
          if (I_dict_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= FIRST_CODE;
          end
        end
        ST_FULL: begin
          if (I_dict_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= FIRST_CODE;
          end
        end
        ST_CLEAR: begin
          r_sync_wren <= 1'b1;
          r_sync_addr <= r_clr_addr;
          r_sync_data <= '0;
          if (r_clr_addr == LAST_CODE) begin
            r_next_code <= FIRST_CODE;
            r_full      <= 1'b0;
            r_state     <= ST_ADD;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_ADD;
        end
      endcase
    end
  end

  lzw_stat_cnt #(.W(32)) u_entry_cnt (
    .i_clk (I_sys_clk),
    .i_rst (I_sys_rst),
    .i_clr (I_state_clr),
    .i_inc (w_legal),
    .o_cnt (O_entry_cnt)
  );

  lzw_stat_cnt #(.W(16)) u_clear_cnt (
    .i_clk (I_sys_clk),
    .i_rst (I_sys_rst),
    .i_clr (I_state_clr),
    .i_inc (w_clr_done),
    .o_cnt (O_clear_cnt)
  );

  lzw_stat_cnt #(.W(16)) u_err_cnt (
    .i_clk (I_sys_clk),
    .i_rst (I_sys_rst),
    .i_clr (I_state_clr),
    .i_inc (w_illegal),
    .o_cnt (O_err_cnt)
  );

  assign O_entry_ready          = (r_state == ST_ADD);
  assign O_dict_full            = r_full;
  assign O_next_code            = r_next_code;
  assign O_dictionary_sync_addr = r_sync_addr;
  assign O_dictionary_sync_data = r_sync_data;
  assign O_dictionary_sync_wren = r_sync_wren;

endmodule

// File: tb/tb_lzw_forward_dictionary_sync.sv
// Bench for lzw_forward_dictionary_sync.
// Reference model plus directed vectors with literal expectations.
module tb_lzw_forward_dictionary_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclr = 1'b0;
  logic        valid = 1'b0;
  logic [13:0] prefix = '0;
  logic [7:0]  chr = '0;
  logic        dreset = 1'b0;
  logic        ready;
  logic [22:0] sdata;
  logic [13:0] saddr;
  logic        swren;
  logic [13:0] next_code;
  logic        full;
  logic [31:0] ent_cnt;
  logic [15:0] clr_cnt;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lzw_forward_dictionary_sync dut (
    .I_sys_clk              (clk),
    .I_sys_rst              (rst),
    .I_state_clr            (sclr),
    .I_entry_valid          (valid),
    .I_entry_prefix         (prefix),
    .I_entry_char           (chr),
    .O_entry_ready          (ready),
    .I_dict_reset           (dreset),
    .O_dictionary_sync_data (sdata),
    .O_dictionary_sync_addr (saddr),
    .O_dictionary_sync_wren (swren),
    .O_next_code            (next_code),
    .O_dict_full            (full),
    .O_entry_cnt            (ent_cnt),
    .O_clear_cnt            (clr_cnt),
    .O_err_cnt              (err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: next free code, remaining sweep writes, full flag
  int          m_next  = 256;
  int          m_sweep = 0;
  bit          m_full  = 0;
  longint      m_ent   = 0;
  int          m_clr   = 0;
  int          m_err   = 0;
  bit          e_wren  = 0;
  int          e_addr  = 0;
  logic [22:0] e_data  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_next = 256; m_sweep = 0; m_full = 0;
      m_ent = 0; m_clr = 0; m_err = 0;
      e_wren = 0; e_addr = 0; e_data = '0;
    end else begin
      e_wren = 0;
      if (m_sweep > 0) begin
        e_wren = 1;
        e_addr = 16384 - m_sweep;
        e_data = '0;
        m_sweep--;
        if (m_sweep == 0) begin
          m_next = 256;
          m_full = 0;
          if (m_clr < 65535) m_clr++;
        end
      end else begin
        if (!m_full && valid) begin
          if (int'(prefix) < m_next) begin
            e_wren = 1;
            e_addr = m_next;
            e_data = {1'b1, prefix, chr};
            if (m_ent < 64'hFFFF_FFFF) m_ent++;
            if (m_next == 16383) m_full = 1;
            else m_next++;
          end else if (m_err < 65535) begin
            m_err++;
          end
        end
        if (dreset) m_sweep = 16128;
      end
      if (sclr) begin
        m_ent = 0; m_clr = 0; m_err = 0;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(!m_full && m_sweep == 0));
    chk("wren", 32'(swren), 32'(e_wren));
    if (e_wren) begin
      chk("addr", 32'(saddr), 32'(e_addr));
      chk("data", 32'(sdata), 32'(e_data));
    end
    chk("next_code", 32'(next_code), 32'(m_next));
    chk("full", 32'(full), 32'(m_full));
    chk("entry_cnt", ent_cnt, m_ent[31:0]);
    chk("clear_cnt", 32'(clr_cnt), 32'(m_clr));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  end

  int  cnt;
  bit  seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_next", 32'(next_code), 32'h100);
    chk("rst_data", 32'(sdata), 32'h0);
    chk("rst_addr", 32'(saddr), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // three back-to-back legal entries
    valid = 1'b1; prefix = 14'h061; chr = 8'h62;
    @(negedge clk);
    chk("e0_data", 32'(sdata), 32'h406162);
    chk("e0_addr", 32'(saddr), 32'h100);
    prefix = 14'h062; chr = 8'h61;
    @(negedge clk);
    chk("e1_data", 32'(sdata), 32'h406261);
    chk("e1_addr", 32'(saddr), 32'h101);
    prefix = 14'h100; chr = 8'h63;
    @(negedge clk);
    chk("e2_data", 32'(sdata), 32'h410063);
    chk("e2_addr", 32'(saddr), 32'h102);
    chk("e2_wren", 32'(swren), 32'd1);
    valid = 1'b0;
    @(negedge clk);
    chk("e_next", 32'(next_code), 32'h103);
    chk("e_cnt", ent_cnt, 32'd3);

    // illegal entry
    valid = 1'b1; prefix = 14'h105; chr = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    chk("ill_wren", 32'(swren), 32'd0);
    chk("ill_err", 32'(err_cnt), 32'd1);
    chk("ill_next", 32'(next_code), 32'h103);

    // fill to the last code
    valid = 1'b1; prefix = 14'h000; chr = 8'h5A;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (full) break;
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_addr", 32'(saddr), 32'h3FFF);
    chk("fill_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("full_ignore", 32'(swren), 32'd0);
    chk("full_next", 32'(next_code), 32'h3FFF);
    valid = 1'b0;

    // restart from FULL
    dreset = 1'b1;
    @(negedge clk);
    dreset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (swren && sdata == '0) cnt++;
      if (ready) break;
    end
    chk("sweep_len", 32'(cnt), 32'd16128);
    chk("sweep_clr", 32'(clr_cnt), 32'd1);
    chk("sweep_next", 32'(next_code), 32'h100);

    valid = 1'b1; prefix = 14'h041; chr = 8'h41;
    @(negedge clk);
    chk("post_addr", 32'(saddr), 32'h100);
    chk("post_data", 32'(sdata), 32'h404141);
    prefix = 14'h000;
    repeat (4) @(negedge clk);

    // restart coincident with the entry at 0x105
    chr = 8'h55; dreset = 1'b1;
    @(negedge clk);
    valid = 1'b0; dreset = 1'b0;
    chk("coin_addr", 32'(saddr), 32'h105);
    chk("coin_data", 32'(sdata), 32'h400055);
    seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (swren && saddr == 14'h105 && sdata == '0) seen = 1;
      if (ready) break;
    end
    chk("coin_wipe", 32'(seen), 32'd1);
    chk("coin_clr", 32'(clr_cnt), 32'd2);

    // counter clear coincident with an accepted entry
    valid = 1'b1; prefix = 14'h000; chr = 8'h01; sclr = 1'b1;
    @(negedge clk);
    valid = 1'b0; sclr = 1'b0;
    chk("sclr_cnt", ent_cnt, 32'd0);
    chk("sclr_wren", 32'(swren), 32'd1);
    chk("sclr_addr", 32'(saddr), 32'h100);

    // asynchronous reset in the middle of a sweep
    dreset = 1'b1;
    @(negedge clk);
    dreset = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wren", 32'(swren), 32'd0);
    chk("arst_addr", 32'(saddr), 32'h0);
    chk("arst_data", 32'(sdata), 32'h0);
    chk("arst_next", 32'(next_code), 32'h100);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_cnt", 32'(clr_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    valid = 1'b1; prefix = 14'h000; chr = 8'h07;
    @(negedge clk);
    valid = 1'b0;
    chk("arst_e_addr", 32'(saddr), 32'h100);
    chk("arst_e_data", 32'(sdata), 32'h400007);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
